// File: rtl/parser_pkg.sv
// Shared IPv4 header bundle used by the RX parser and the TX header builder.
// ipv4_header_t carries the 20-byte option-less header fields.
package parser_pkg;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  qos;
    logic [15:0] total_length;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] hdr_checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_header_t;

endpackage

// File: rtl/ipv4_header_builder.sv
// Serialises one ipv4_header_t into three 64-bit AXI-stream beats (20 bytes).
// Ports: aclk/areset, hdr_in/valid/ready, m_axis_*, hdr_err, header_sent.
module ipv4_header_builder
  import parser_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter bit CALC_CSUM = 1'b1
) (
  input  logic                aclk,
  input  logic                areset,
  input  ipv4_header_t        hdr_in,
  input  logic                hdr_valid,
  output logic                hdr_ready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                hdr_err,
  output logic                header_sent
);

  if (DATA_W != 64) begin : g_bad_w
    $error("ipv4_header_builder: DATA_W must be 64");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_BEAT0,
    S_BEAT1,
    S_BEAT2
  } state_t;

  state_t state, state_d;

  ipv4_header_t hdr_q;
  logic [15:0]  csum_q;
  logic [15:0]  csum_calc;
  logic [15:0]  csum_d;
  logic         sent_q;

  logic accept;
  logic beat_hs;

  logic [DATA_W-1:0]   tdata_d;
  logic [DATA_W/8-1:0] tkeep_d;
  logic                tvalid_d;
  logic                tlast_d;

  logic [15:0] words [10];
  logic [31:0] sum;
  logic [31:0] fold1;
  logic [15:0] fold2;

  assign hdr_ready = (state == S_IDLE);
  assign accept    = hdr_valid && hdr_ready;
  assign beat_hs   = m_axis_tvalid && m_axis_tready;

  // Flag is evaluated from the captured header in the cycle after accept.
  assign hdr_err = (state == S_CSUM) &&
                   ((hdr_q.version != 4'd4) || (hdr_q.ihl != 4'd5));

  assign header_sent = sent_q;

  // Version/IHL are always emitted as 0x45, so the sum uses that too.
  assign words[0] = {8'h45, hdr_q.qos};
  assign words[1] = hdr_q.total_length;
  assign words[2] = hdr_q.id;
  assign words[3] = {hdr_q.flags, hdr_q.frag_offset};
  assign words[4] = {hdr_q.ttl, hdr_q.protocol};
  assign words[5] = 16'h0000;
  assign words[6] = hdr_q.src_ip[31:16];
  assign words[7] = hdr_q.src_ip[15:0];
  assign words[8] = hdr_q.dst_ip[31:16];
  assign words[9] = hdr_q.dst_ip[15:0];

  always_comb begin
    sum = 32'd0;
    for (int i = 0; i < 10; i++) begin
      sum = sum + {16'h0000, words[i]};
    end
    fold1     = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
    fold2     = fold1[15:0] + fold1[31:16];
    csum_calc = ~fold2;
  end

  assign csum_d = CALC_CSUM ? csum_calc : hdr_q.hdr_checksum;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept)  state_d = S_CSUM;
      S_CSUM:               state_d = S_BEAT0;
      S_BEAT0: if (beat_hs) state_d = S_BEAT1;
      S_BEAT1: if (beat_hs) state_d = S_BEAT2;
      S_BEAT2: if (beat_hs) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // Beat contents follow the next state so outputs come straight from flops.
  always_comb begin
    tdata_d  = '0;
    tkeep_d  = '0;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    case (state_d)
      S_BEAT0: begin
        tdata_d  = {hdr_q.frag_offset[7:0],
                    hdr_q.flags, hdr_q.frag_offset[12:8],
                    hdr_q.id[7:0], hdr_q.id[15:8],
                    hdr_q.total_length[7:0],
                    hdr_q.total_length[15:8],
                    hdr_q.qos, 8'h45};
        tkeep_d  = 8'hFF;
        tvalid_d = 1'b1;
      end
      S_BEAT1: begin
        tdata_d  = {hdr_q.src_ip[7:0], hdr_q.src_ip[15:8],
                    hdr_q.src_ip[23:16], hdr_q.src_ip[31:24],
                    csum_q[7:0], csum_q[15:8],
                    hdr_q.protocol, hdr_q.ttl};
        tkeep_d  = 8'hFF;
        tvalid_d = 1'b1;
      end
      S_BEAT2: begin
        tdata_d  = {32'h0000_0000,
                    hdr_q.dst_ip[7:0], hdr_q.dst_ip[15:8],
                    hdr_q.dst_ip[23:16], hdr_q.dst_ip[31:24]};
        tkeep_d  = 8'h0F;
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hdr_q         <= '0;
      csum_q        <= '0;
      sent_q        <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        hdr_q <= hdr_in;
      end
      if (state == S_CSUM) begin
        csum_q <= csum_d;
      end
      sent_q        <= (state == S_BEAT2) && beat_hs;
      m_axis_tdata  <= tdata_d;
      m_axis_tkeep  <= tkeep_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
    end
  end

endmodule

// File: tb/tb_ipv4_header_builder.sv
// Directed bench for ipv4_header_builder.
// Two instances: computed checksum and pass-through checksum.
module tb_ipv4_header_builder;
  import parser_pkg::*;

  localparam logic [63:0] B0   = 64'h0040_0000_7300_0045;
  localparam logic [63:0] B1   = 64'h0100_A8C0_61B8_1140;
  localparam logic [63:0] B2   = 64'h0000_0000_C700_A8C0;
  localparam logic [63:0] B0_2 = 64'h0040_3412_7300_0045;
  localparam logic [63:0] B1_2 = 64'h0100_A8C0_2DA6_1140;

  logic clk = 1'b0;
  logic areset;
  ipv4_header_t hdr_in;
  logic hdr_valid, hdr_valid0;
  logic tready;

  logic        hdr_ready, tvalid, tlast, hdr_err, header_sent;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  logic        hdr_ready0, tvalid0, tlast0, hdr_err0, header_sent0;
  logic [63:0] tdata0;
  logic [7:0]  tkeep0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int sent_n = 0, err_n = 0;
  int sent_cyc = 0, err_cyc = 0;
  int acc_q[$];
  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  logic        bl[$];
  int          bc[$];

  logic        pv = 0, pr = 0, pl = 0;
  logic [63:0] pd = 0;
  logic [7:0]  pk = 0;

  ipv4_header_t h1, h2, h4, h5;

  ipv4_header_builder #(.DATA_W(64), .CALC_CSUM(1'b1)) dut (
    .aclk(clk), .areset(areset),
    .hdr_in(hdr_in), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tready(tready),
    .hdr_err(hdr_err), .header_sent(header_sent)
  );

  ipv4_header_builder #(.DATA_W(64), .CALC_CSUM(1'b0)) dut0 (
    .aclk(clk), .areset(areset),
    .hdr_in(hdr_in), .hdr_valid(hdr_valid0), .hdr_ready(hdr_ready0),
    .m_axis_tdata(tdata0), .m_axis_tkeep(tkeep0),
    .m_axis_tvalid(tvalid0), .m_axis_tlast(tlast0),
    .m_axis_tready(tready),
    .hdr_err(hdr_err0), .header_sent(header_sent0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hdr_valid && hdr_ready) acc_q.push_back(cyc);
    if (tvalid && tready) begin
      bd.push_back(tdata);
      bk.push_back(tkeep);
      bl.push_back(tlast);
      bc.push_back(cyc);
    end
    if (header_sent) begin
      sent_n++;
      sent_cyc = cyc;
    end
    if (hdr_err) begin
      err_n++;
      err_cyc = cyc;
    end
    if (pv && !pr && !areset) begin
      chk("hold_valid", {63'd0, tvalid}, 64'd1);
      chk("hold_data", tdata, pd);
      chk("hold_keep", {56'd0, tkeep}, {56'd0, pk});
      chk("hold_last", {63'd0, tlast}, {63'd0, pl});
    end
    pv = tvalid && !areset;
    pr = tready;
    pd = tdata;
    pk = tkeep;
    pl = tlast;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    acc_q.delete();
    bd.delete();
    bk.delete();
    bl.delete();
    bc.delete();
  endtask

  task automatic send_hdr(input ipv4_header_t h);
    logic acc;
    acc = 1'b0;
    hdr_in = h;
    hdr_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = hdr_ready;
      tick;
    end
    hdr_valid = 1'b0;
    chk("accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_sent(input int target, input int budget);
    for (int i = 0; i < budget && sent_n < target; i++) tick;
    chk("sent_in_time", {63'd0, sent_n >= target}, 64'd1);
  endtask

  task automatic check_pkt(input string tag, input int base,
                           input logic [63:0] d0,
                           input logic [63:0] d1,
                           input logic [63:0] d2);
    chk({tag, "_d0"}, bd[base], d0);
    chk({tag, "_d1"}, bd[base+1], d1);
    chk({tag, "_d2"}, bd[base+2], d2);
    chk({tag, "_k0"}, {56'd0, bk[base]}, 64'hFF);
    chk({tag, "_k1"}, {56'd0, bk[base+1]}, 64'hFF);
    chk({tag, "_k2"}, {56'd0, bk[base+2]}, 64'h0F);
    chk({tag, "_last"}, {61'd0, bl[base], bl[base+1], bl[base+2]}, 64'd1);
  endtask

  initial begin
    int n0, e0, nacc, nb;
    logic acc;
    logic [63:0] b1;

    h1 = '{version: 4'd4, ihl: 4'd5, qos: 8'h00,
           total_length: 16'h0073, id: 16'h0000,
           flags: 3'd2, frag_offset: 13'd0,
           ttl: 8'h40, protocol: 8'h11, hdr_checksum: 16'h0000,
           src_ip: 32'hC0A8_0001, dst_ip: 32'hC0A8_00C7};
    h2 = h1;
    h2.id = 16'h1234;
    h4 = h1;
    h4.hdr_checksum = 16'hBEEF;
    h5 = h1;
    h5.ihl = 4'd6;

    areset = 1'b1;
    hdr_in = '0;
    hdr_valid = 1'b0;
    hdr_valid0 = 1'b0;
    tready = 1'b1;
    repeat (3) tick;
    chk("rst_ready", {63'd0, hdr_ready}, 64'd1);
    chk("rst_valid", {63'd0, tvalid}, 64'd0);
    chk("rst_last", {63'd0, tlast}, 64'd0);
    chk("rst_data", tdata, 64'd0);
    chk("rst_keep", {56'd0, tkeep}, 64'd0);
    chk("rst_err", {63'd0, hdr_err}, 64'd0);
    chk("rst_sent", {63'd0, header_sent}, 64'd0);
    areset = 1'b0;
    repeat (2) tick;

    // 1: basic packet, no back-pressure
    clear_mon();
    n0 = sent_n;
    e0 = err_n;
    send_hdr(h1);
    wait_sent(n0 + 1, 30);
    repeat (3) tick;
    chk("t1_beats", bd.size(), 3);
    check_pkt("t1", 0, B0, B1, B2);
    chk("t1_latency", bc[0] - acc_q[0], 2);
    chk("t1_sent_once", sent_n - n0, 1);
    chk("t1_sent_cyc", sent_cyc - bc[2], 1);
    chk("t1_no_err", err_n - e0, 0);

    // 2: three stall cycles on every beat
    clear_mon();
    n0 = sent_n;
    tready = 1'b0;
    hdr_in = h1;
    hdr_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = hdr_ready;
      tick;
    end
    hdr_valid = 1'b0;
    begin
      int st;
      logic hs;
      st = 0;
      for (int i = 0; i < 80 && sent_n == n0; i++) begin
        hs = tvalid && tready;
        tick;
        if (hs) begin
          tready = 1'b0;
          st = 0;
        end else if (tvalid) begin
          st++;
          if (st == 3) tready = 1'b1;
        end
      end
    end
    tready = 1'b1;
    chk("t2_sent", {63'd0, sent_n > n0}, 64'd1);
    repeat (4) tick;
    chk("t2_beats", bd.size(), 3);
    check_pkt("t2", 0, B0, B1, B2);
    chk("t2_gap", bc[1] - bc[0], 4);
    chk("t2_sent_once", sent_n - n0, 1);

    // 3: back-to-back headers with valid held
    clear_mon();
    n0 = sent_n;
    hdr_in = h1;
    hdr_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 60 && nacc < 2; i++) begin
      acc = hdr_valid && hdr_ready;
      tick;
      if (acc) begin
        nacc++;
        hdr_in = h2;
      end
    end
    hdr_valid = 1'b0;
    wait_sent(n0 + 2, 40);
    repeat (3) tick;
    chk("t3_beats", bd.size(), 6);
    chk("t3_acc_gap", acc_q[1] - acc_q[0], 5);
    chk("t3_b0_gap", bc[3] - bc[0], 5);
    check_pkt("t3a", 0, B0, B1, B2);
    check_pkt("t3b", 3, B0_2, B1_2, B2);

    // 4: checksum passed through unchanged
    hdr_in = h4;
    hdr_valid0 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = hdr_ready0;
      tick;
    end
    hdr_valid0 = 1'b0;
    chk("t4_accept", {63'd0, acc}, 64'd1);
    nb = 0;
    b1 = '0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid0) begin
        if (nb == 1) b1 = tdata0;
        nb++;
      end
      tick;
    end
    chk("t4_beats", nb, 3);
    chk("t4_csum", {48'd0, b1[31:16]}, 64'hEFBE);
    chk("t4_ttl_proto", {48'd0, b1[15:0]}, 64'h1140);

    // 5: bad IHL flagged, stream still 0x45
    clear_mon();
    n0 = sent_n;
    e0 = err_n;
    send_hdr(h5);
    wait_sent(n0 + 1, 30);
    repeat (3) tick;
    chk("t5_err_once", err_n - e0, 1);
    chk("t5_err_cyc", err_cyc - acc_q[0], 1);
    chk("t5_beats", bd.size(), 3);
    check_pkt("t5", 0, B0, B1, B2);

    // 6: reset while stalled in beat1
    clear_mon();
    tready = 1'b1;
    send_hdr(h1);
    for (int i = 0; i < 10; i++) begin
      acc = tvalid && tready;
      tick;
      if (acc) begin
        tready = 1'b0;
        break;
      end
    end
    tick;
    chk("t6_in_b1", tdata, B1);
    areset = 1'b1;
    tick;
    chk("t6_rst_valid", {63'd0, tvalid}, 64'd0);
    chk("t6_rst_ready", {63'd0, hdr_ready}, 64'd1);
    areset = 1'b0;
    tready = 1'b1;
    clear_mon();
    repeat (4) tick;
    chk("t6_no_partial", bd.size(), 0);
    n0 = sent_n;
    send_hdr(h1);
    wait_sent(n0 + 1, 30);
    repeat (3) tick;
    chk("t6_beats", bd.size(), 3);
    check_pkt("t6", 0, B0, B1, B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
